// File: rtl/train_pkg.sv
// Shared constants for the two-train shared-track supervisor:
// state codes, drive codes and switch positions.
package train_pkg;

  localparam int         ST_W  = 3;

  localparam logic [2:0] ABOUT = 3'd0;
  localparam logic [2:0] AIN   = 3'd1;
  localparam logic [2:0] BIN   = 3'd2;
  localparam logic [2:0] ASTOP = 3'd3;
  localparam logic [2:0] BSTOP = 3'd4;

  localparam logic [1:0] DRV_FWD  = 2'b01;
  localparam logic [1:0] DRV_STOP = 2'b00;

  localparam logic       SW_A = 1'b0;
  localparam logic       SW_B = 1'b1;

endpackage

// File: rtl/train_controller.sv
// Moore supervisor granting the shared track section to one train at a time.
// Sensors are level-sensitive and assumed synchronous to clk.
module train_controller
  import train_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       S4,
  output logic       SW1,
  output logic       SW2,
  output logic [1:0] DA,
  output logic [1:0] DB
);

  logic [ST_W-1:0] curr_st;
  logic [ST_W-1:0] next_st;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curr_st <= ABOUT;
    end else begin
      curr_st <= next_st;
    end
  end

  // Next-state logic; earlier conditions take priority, otherwise hold
  always_comb begin
    next_st = curr_st;
    case (curr_st)
      ABOUT: begin
        if (S1) begin
          next_st = AIN;
        end else if (S2) begin
          next_st = BIN;
        end else begin
          next_st = ABOUT;
        end
      end
      AIN: begin
        if (S4) begin
          next_st = ABOUT;
        end else if (S2) begin
          next_st = BSTOP;
        end else begin
          next_st = AIN;
        end
      end
      BIN: begin
        if (S3) begin
          next_st = ABOUT;
        end else if (S1) begin
          next_st = ASTOP;
        end else begin
          next_st = BIN;
        end
      end
      ASTOP: begin
        if (S3) begin
          next_st = AIN;
        end else begin
          next_st = ASTOP;
        end
      end
      BSTOP: begin
        if (S4) begin
          next_st = BIN;
        end else begin
          next_st = BSTOP;
        end
      end
      default: next_st = ABOUT;
    endcase
  end

  // Output decode; unused codes drive the free-section outputs
  always_comb begin
    SW1 = SW_A;
    SW2 = SW_A;
    DA  = DRV_FWD;
    DB  = DRV_FWD;
    case (curr_st)
      ABOUT, AIN: begin
        SW1 = SW_A;
        SW2 = SW_A;
        DA  = DRV_FWD;
        DB  = DRV_FWD;
      end
      BIN: begin
        SW1 = SW_B;
        SW2 = SW_B;
        DA  = DRV_FWD;
        DB  = DRV_FWD;
      end
      ASTOP: begin
        SW1 = SW_B;
        SW2 = SW_B;
        DA  = DRV_STOP;
        DB  = DRV_FWD;
      end
      BSTOP: begin
        SW1 = SW_A;
        SW2 = SW_A;
        DA  = DRV_FWD;
        DB  = DRV_STOP;
      end
      default: begin
        SW1 = SW_A;
        SW2 = SW_A;
        DA  = DRV_FWD;
        DB  = DRV_FWD;
      end
    endcase
  end

endmodule

// File: tb/tb_train_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then
// random sensor traffic compared every cycle against an occupancy model.
module tb_train_controller;

  logic       clk;
  logic       rst_n;
  logic       S1, S2, S3, S4;
  logic       SW1, SW2;
  logic [1:0] DA, DB;

  int tests;
  int fails;

  train_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .S1   (S1),
    .S2   (S2),
    .S3   (S3),
    .S4   (S4),
    .SW1  (SW1),
    .SW2  (SW2),
    .DA   (DA),
    .DB   (DB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the shared section and who is held waiting for it
  typedef enum int {NOBODY, TRAIN_A, TRAIN_B} who_t;
  who_t owner;
  who_t waiting;
  bit   m_illegal;

  function automatic logic [2:0] model_code();
    if (m_illegal) return 3'd5;
    if (owner == NOBODY) return 3'd0;
    if (owner == TRAIN_A) return (waiting == TRAIN_B) ? 3'd4 : 3'd1;
    return (waiting == TRAIN_A) ? 3'd3 : 3'd2;
  endfunction

  // {SW1,SW2,DA,DB}: switches follow the owner, a waiting train is stopped
  function automatic logic [5:0] model_outs();
    logic sw;
    logic [1:0] da, db;
    sw = (!m_illegal && owner == TRAIN_B) ? 1'b1 : 1'b0;
    da = (!m_illegal && waiting == TRAIN_A) ? 2'b00 : 2'b01;
    db = (!m_illegal && waiting == TRAIN_B) ? 2'b00 : 2'b01;
    return {sw, sw, da, db};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || m_illegal) begin
      owner   = NOBODY;
      waiting = NOBODY;
    end else if (owner == NOBODY) begin
      if (S1) owner = TRAIN_A;
      else if (S2) owner = TRAIN_B;
    end else if (owner == TRAIN_A) begin
      if (waiting == NOBODY) begin
        if (S4) owner = NOBODY;
        else if (S2) waiting = TRAIN_B;
      end else if (S4) begin
        owner   = TRAIN_B;
        waiting = NOBODY;
      end
    end else begin
      if (waiting == NOBODY) begin
        if (S3) owner = NOBODY;
        else if (S1) waiting = TRAIN_A;
      end else if (S3) begin
        owner   = TRAIN_A;
        waiting = NOBODY;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model while out of reset
  always @(negedge clk) begin
    if (rst_n && !m_illegal) begin
      chk("model_state", {5'd0, dut.curr_st}, {5'd0, model_code()});
      chk("model_outs", {2'd0, SW1, SW2, DA, DB}, {2'd0, model_outs()});
    end
  end

  function automatic logic [5:0] lit_outs(input logic [2:0] code);
    case (code)
      3'd2:    return 6'b11_01_01;
      3'd3:    return 6'b11_00_01;
      3'd4:    return 6'b00_01_00;
      default: return 6'b00_01_01;
    endcase
  endfunction

  task automatic step(input logic [3:0] s, input logic [2:0] exp_code, input string name);
    @(negedge clk);
    {S1, S2, S3, S4} = s;
    @(posedge clk);
    #1;
    chk({name, "_st"}, {5'd0, dut.curr_st}, {5'd0, exp_code});
    chk({name, "_out"}, {2'd0, SW1, SW2, DA, DB}, {2'd0, lit_outs(exp_code)});
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_illegal = 1'b0;
    {S1, S2, S3, S4} = 4'b0000;
    rst_n = 1'b0;
    #2;
    chk("reset_st", {5'd0, dut.curr_st}, 8'd0);
    chk("reset_out", {2'd0, SW1, SW2, DA, DB}, 8'b00_00_01_01);
    @(negedge clk);
    rst_n = 1'b1;

    // A then B conflict
    step(4'b1000, 3'd1, "a_enter");
    step(4'b0100, 3'd4, "b_held");
    step(4'b0001, 3'd2, "b_enter");
    step(4'b0010, 3'd0, "b_clear");
    // B then A conflict
    step(4'b0100, 3'd2, "b_enter2");
    step(4'b1000, 3'd3, "a_held");
    step(4'b0010, 3'd1, "a_enter2");
    step(4'b0001, 3'd0, "a_clear");
    // Simultaneous requests
    step(4'b1100, 3'd1, "both_req");
    step(4'b0101, 3'd0, "s2s4_ain");
    step(4'b0100, 3'd2, "b_enter3");
    step(4'b1010, 3'd0, "s1s3_bin");
    // Held sensors
    step(4'b1000, 3'd1, "h_ain");
    step(4'b0100, 3'd4, "h_bstop");
    step(4'b0001, 3'd2, "h_s4_1");
    step(4'b0001, 3'd2, "h_s4_2");
    step(4'b0010, 3'd0, "h_s3_bin");
    step(4'b0100, 3'd2, "h_bin");
    step(4'b1000, 3'd3, "h_astop");
    step(4'b0010, 3'd1, "h_s3_astop");
    step(4'b0001, 3'd0, "h_done");

    // Asynchronous reset from ASTOP
    step(4'b0100, 3'd2, "r_bin");
    step(4'b1000, 3'd3, "r_astop");
    @(negedge clk);
    {S1, S2, S3, S4} = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_st", {5'd0, dut.curr_st}, 8'd0);
    chk("async_out", {2'd0, SW1, SW2, DA, DB}, 8'b00_00_01_01);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0000, 3'd0, "after_rst");

    // Illegal code recovers to ABOUT
    @(negedge clk);
    {S1, S2, S3, S4} = 4'b0000;
    #2;
    m_illegal = 1'b1;
    force dut.curr_st = 3'd5;
    #1;
    chk("illegal_out", {2'd0, SW1, SW2, DA, DB}, 8'b00_00_01_01);
    release dut.curr_st;
    @(posedge clk);
    #1;
    m_illegal = 1'b0;
    chk("illegal_next", {5'd0, dut.curr_st}, 8'd0);

    // Random traffic with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      S1 = ($urandom_range(0, 3) == 0);
      S2 = ($urandom_range(0, 3) == 0);
      S3 = ($urandom_range(0, 3) == 0);
      S4 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rand_rst", {2'd0, SW1, SW2, DA, DB}, 8'b00_00_01_01);
        #1;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/train_controller.md
# train_controller

Moore-type supervisory FSM for a two-train, shared-track layout. Trains A and B each run on their own loop, and the loops share one common track section. Four track sensors (S1..S4) report train positions. The block drives two track switches (SW1, SW2) and the two train direction/speed codes (DA, DB) so that only one train occupies the shared section at a time. It sits between the sensor input conditioning and the track/motor drivers.

## Interface
Parameters: none.

- clk: input, 1 bit. System clock; all state changes occur on its rising edge.
- rst_n: input, 1 bit. Reset is asynchronous and active-low. It forces state ABOUT.
- S1: input, 1 bit. Train A approaching the shared section (A requests entry).
- S2: input, 1 bit. Train B approaching the shared section (B requests entry).
- S3: input, 1 bit. Train B has cleared the shared section.
- S4: input, 1 bit. Train A has cleared the shared section.
- SW1: output, 1 bit. Switch 1 position. 0 routes loop A, 1 routes loop B.
- SW2: output, 1 bit. Switch 2 position, same encoding as SW1.
- DA: output, 2 bits. Train A drive code: 2'b01 = forward, 2'b00 = stop.
- DB: output, 2 bits. Train B drive code, same encoding as DA.

Port order is fixed as: clk, rst_n, S1, S2, S3, S4, SW1, SW2, DA, DB. The state register is named curr_st, is 3 bits wide, and is reachable hierarchically for monitoring.

## Operation
States and their encodings:
- ABOUT = 3'd0: shared section free.
- AIN = 3'd1: A is in the section.
- BIN = 3'd2: B is in the section.
- ASTOP = 3'd3: A is held while B is in the section.
- BSTOP = 3'd4: B is held while A is in the section.

Transitions are evaluated each clock. Where more than one condition applies, the first listed takes priority. If no condition applies, the state holds.
- ABOUT: S1 → AIN (this includes S1 and S2 both high; A wins). Otherwise S2 → BIN.
- AIN: S4 → ABOUT. Otherwise S2 → BSTOP.
- BIN: S3 → ABOUT. Otherwise S1 → ASTOP.
- ASTOP: S3 → AIN.
- BSTOP: S4 → BIN.
- Unused codes 5–7: next state is ABOUT, and the outputs are the ABOUT outputs.

Outputs are pure Moore outputs, decoded combinationally from curr_st:
- ABOUT: SW1=0, SW2=0, DA=01, DB=01.
- AIN: SW1=0, SW2=0, DA=01, DB=01.
- BIN: SW1=1, SW2=1, DA=01, DB=01.
- ASTOP: SW1=1, SW2=1, DA=00, DB=01.
- BSTOP: SW1=0, SW2=0, DA=01, DB=00.

Sensor levels, not edges, are used. A sensor held high for several cycles gives no further transitions beyond those in the table. For example, S4 held in BIN is ignored.

## Timing
- Reset value: curr_st=ABOUT. This gives SW1=0, SW2=0, DA=01, DB=01 immediately on the falling edge of rst_n, with no clock required.
- Reset deassertion: the FSM is sampled at the first rising clk edge after deassertion.
- Sensor-to-output latency: one clock. A sensor sampled at edge N changes curr_st and the outputs right after edge N.
- Sensor inputs are assumed synchronous to clk. No synchronizers are included in this block.
- Reset asserted mid-operation, from any state, returns the FSM to ABOUT asynchronously.

## Structure
- Shared package, train_pkg, holds:
  - the state localparams ABOUT/AIN/BIN/ASTOP/BSTOP and the state width (3);
  - the drive codes DRV_FWD=2'b01 and DRV_STOP=2'b00;
  - the switch codes SW_A=0 and SW_B=1.
- Single flat module. Keep three processes: the state register, the next-state logic, and the output decode. No sub-module is needed.

## Test plan
- Reset: pulse rst_n low for one cycle with all sensors at 0 → curr_st=0, SW1=SW2=0, DA=DB=01, before any clock edge.
- A then B conflict: S1 for one cycle → AIN. Then S2 → BSTOP (DB=00). Then S4 → BIN (SW1=SW2=1, DB=01). Then S3 → ABOUT.
- B then A conflict: from ABOUT, S2 → BIN. Then S1 → ASTOP (DA=00, SW1=SW2=1). Then S3 → AIN (DA=01, SW=0). Then S4 → ABOUT.
- Simultaneous requests: S1=S2=1 in ABOUT → AIN. S2=S4=1 in AIN → ABOUT. S1=S3=1 in BIN → ABOUT.
- Held sensors: S4 held two cycles after BSTOP → BIN and stays in BIN. S3 alone in ASTOP or BIN is handled as specified.
- Async reset from ASTOP: assert rst_n between clock edges → ABOUT outputs appear immediately. Force an illegal code (5) into curr_st → next clock gives ABOUT.
